// File: rtl/sram_memory_pkg.sv
// Shared constants for the single-port SRAM model: default geometry and
// the active-low pin encodings of the compiler-style CEN/WEN controls.
package sram_memory_pkg;

  localparam int AW_DEF    = 7;
  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 128;

  localparam logic ACCESS = 1'b0;
  localparam logic WRITE  = 1'b0;
  localparam logic READ   = 1'b1;

endpackage

// File: rtl/sram_memory_if.sv
// Access bus of the SRAM macro: enable, write enable, address, write data
// and the registered read data returned by the memory.
interface sram_memory_if #(
  parameter int AW = 7,
  parameter int DW = 16
);

  logic          CEN;
  logic          WEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  modport master (output CEN, output WEN, output A, output D, input Q);
  modport slave  (input CEN, input WEN, input A, input D, output Q);

endinterface

// File: rtl/sram_addr_decode.sv
// Word-address decoder: one-hot word select plus a flag telling whether the
// address falls inside the populated part of the address space.
module sram_addr_decode
  import sram_memory_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] sel,
  output logic             in_range
);

  // DEPTH may equal 2**AW, so the bound needs one extra bit
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  // Decode the address into a one-hot select and a range flag
  always_comb begin
    in_range = ({1'b0, addr} < DEPTH_W);
    sel      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) begin
        sel[i] = 1'b1;
      end else begin
        sel[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_memory.sv
// Single-port synchronous SRAM model: one read or write per clock, registered
// write-through output, synchronous clear of both array and output.
module sram_memory
  import sram_memory_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic          CLK,
  input logic          RST,
  sram_memory_if.slave bus
);

  logic [DW-1:0]    mem_r [DEPTH];
  logic [DW-1:0]    q_r;
  logic [DW-1:0]    rdata_s;
  logic [DEPTH-1:0] sel_s;
  logic             in_range_s;

  sram_addr_decode #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_decode (
    .addr     (bus.A),
    .sel      (sel_s),
    .in_range (in_range_s)
  );

  // AND-OR read mux; an out-of-range address selects nothing and yields zero
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdata_s = rdata_s | (mem_r[i] & {DW{sel_s[i]}});
    end
  end

  // Array update and output register; reset wins over any access
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      q_r <= '0;
    end else if (bus.CEN == ACCESS) begin
      if (bus.WEN == WRITE) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (sel_s[i]) begin
            mem_r[i] <= bus.D;
          end
        end
        q_r <= in_range_s ? bus.D : '0;
      end else begin
        q_r <= rdata_s;
      end
    end
  end

  assign bus.Q = q_r;

endmodule

// File: tb/tb_sram_memory.sv
// Self-checking bench: a full-depth and a DEPTH=100 instance driven in
// lockstep, compared against a word-array reference model.
module tb_sram_memory;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int DEPTH0 = 128;
  localparam int DEPTH1 = 100;

  logic CLK;
  logic RST;
  int   errors;
  int   checks;

  logic [DW-1:0] m0 [DEPTH0];
  logic [DW-1:0] m1 [DEPTH1];
  logic [DW-1:0] q0;
  logic [DW-1:0] q1;

  sram_memory_if #(.AW(AW), .DW(DW)) bus0 ();
  sram_memory_if #(.AW(AW), .DW(DW)) bus1 ();

  sram_memory #(.AW(AW), .DW(DW), .DEPTH(DEPTH0)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0)
  );

  sram_memory #(.AW(AW), .DW(DW), .DEPTH(DEPTH1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply one clock edge to both DUTs and to the reference model.
  task automatic step(input logic rst, input logic cen, input logic wen,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    RST = rst;
    bus0.CEN = cen; bus0.WEN = wen; bus0.A = a; bus0.D = d;
    bus1.CEN = cen; bus1.WEN = wen; bus1.A = a; bus1.D = d;
    @(posedge CLK);
    #1;
    if (rst) begin
      for (int i = 0; i < DEPTH0; i++) m0[i] = '0;
      for (int i = 0; i < DEPTH1; i++) m1[i] = '0;
      q0 = '0;
      q1 = '0;
    end else if (!cen) begin
      if (!wen) begin
        m0[a] = d;
        q0 = d;
        if (int'(a) < DEPTH1) begin
          m1[a] = d;
          q1 = d;
        end else begin
          q1 = '0;
        end
      end else begin
        q0 = m0[a];
        q1 = (int'(a) < DEPTH1) ? m1[a] : '0;
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 7'd0, 16'd0);
    step(1'b1, 1'b1, 1'b1, 7'd0, 16'd0);
    step(1'b0, 1'b1, 1'b1, 7'd0, 16'd0);
    checks++;
    if (bus0.Q !== 16'd0) begin
      errors++;
      $display("FAIL reset_q0 got=%h exp=%h", bus0.Q, 16'd0);
    end
    checks++;
    if (bus1.Q !== 16'd0) begin
      errors++;
      $display("FAIL reset_q1 got=%h exp=%h", bus1.Q, 16'd0);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 7'($urandom_range(0, 127)), 16'($urandom));
      checks++;
      if (bus0.Q !== 16'd0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", bus0.A, bus0.Q, 16'd0);
      end
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 128; k++) begin
      step(1'b0, 1'b0, 1'b0, 7'(k), 16'(k));
      checks++;
      if (bus0.Q !== 16'(k)) begin
        errors++;
        $display("FAIL fill_wt addr=%0d got=%h exp=%h", k, bus0.Q, 16'(k));
      end
    end
    for (int k = 0; k < 128; k++) begin
      step(1'b0, 1'b0, 1'b1, 7'(k), 16'($urandom));
      checks++;
      if (bus0.Q !== 16'(k)) begin
        errors++;
        $display("FAIL fill_read addr=%0d got=%h exp=%h", k, bus0.Q, 16'(k));
      end
      checks++;
      if (bus1.Q !== q1) begin
        errors++;
        $display("FAIL fill_read_d100 addr=%0d got=%h exp=%h", k, bus1.Q, q1);
      end
    end
    step(1'b0, 1'b0, 1'b1, 7'd0, 16'd0);
    checks++;
    if (bus0.Q !== 16'd0) begin
      errors++;
      $display("FAIL fill_wrap got=%h exp=%h", bus0.Q, 16'd0);
    end
  endtask

  task automatic test_write_through();
    step(1'b0, 1'b0, 1'b0, 7'd5, 16'hBEEF);
    checks++;
    if (bus0.Q !== 16'hBEEF) begin
      errors++;
      $display("FAIL wt_write got=%h exp=%h", bus0.Q, 16'hBEEF);
    end
    step(1'b0, 1'b0, 1'b1, 7'd5, 16'd0);
    checks++;
    if (bus0.Q !== 16'hBEEF) begin
      errors++;
      $display("FAIL wt_read got=%h exp=%h", bus0.Q, 16'hBEEF);
    end
  endtask

  task automatic test_no_access();
    step(1'b0, 1'b0, 1'b1, 7'd3, 16'd0);
    step(1'b0, 1'b1, 1'b0, 7'd5, 16'h1234);
    checks++;
    if (bus0.Q !== 16'd3) begin
      errors++;
      $display("FAIL idle_hold got=%h exp=%h", bus0.Q, 16'd3);
    end
    step(1'b0, 1'b0, 1'b1, 7'd5, 16'd0);
    checks++;
    if (bus0.Q !== 16'hBEEF) begin
      errors++;
      $display("FAIL idle_read got=%h exp=%h", bus0.Q, 16'hBEEF);
    end
  endtask

  task automatic test_reset_priority();
    step(1'b1, 1'b0, 1'b0, 7'd9, 16'hFFFF);
    checks++;
    if (bus0.Q !== 16'd0) begin
      errors++;
      $display("FAIL rstpri_q got=%h exp=%h", bus0.Q, 16'd0);
    end
    step(1'b0, 1'b0, 1'b1, 7'd9, 16'd0);
    checks++;
    if (bus0.Q !== 16'd0) begin
      errors++;
      $display("FAIL rstpri_read9 got=%h exp=%h", bus0.Q, 16'd0);
    end
    step(1'b0, 1'b0, 1'b1, 7'd5, 16'd0);
    checks++;
    if (bus0.Q !== 16'd0) begin
      errors++;
      $display("FAIL rstpri_read5 got=%h exp=%h", bus0.Q, 16'd0);
    end
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < DEPTH1; k++) begin
      step(1'b0, 1'b0, 1'b0, 7'(k), 16'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 7'd120, 16'h00AA);
    step(1'b0, 1'b0, 1'b1, 7'd120, 16'd0);
    checks++;
    if (bus1.Q !== 16'd0) begin
      errors++;
      $display("FAIL oor_read got=%h exp=%h", bus1.Q, 16'd0);
    end
    for (int k = 0; k < DEPTH1; k++) begin
      step(1'b0, 1'b0, 1'b1, 7'(k), 16'd0);
      checks++;
      if (bus1.Q !== m1[k]) begin
        errors++;
        $display("FAIL oor_keep addr=%0d got=%h exp=%h", k, bus1.Q, m1[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
           7'($urandom), 16'($urandom));
      checks++;
      if (bus0.Q !== q0) begin
        errors++;
        $display("FAIL rand_q0 n=%0d got=%h exp=%h", n, bus0.Q, q0);
      end
      checks++;
      if (bus1.Q !== q1) begin
        errors++;
        $display("FAIL rand_q1 n=%0d got=%h exp=%h", n, bus1.Q, q1);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    q0 = '0;
    q1 = '0;
    RST = 1'b1;
    bus0.CEN = 1'b1; bus0.WEN = 1'b1; bus0.A = '0; bus0.D = '0;
    bus1.CEN = 1'b1; bus1.WEN = 1'b1; bus1.A = '0; bus1.D = '0;
    test_reset();
    test_fill();
    test_write_through();
    test_no_access();
    test_reset_priority();
    test_out_of_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
